// File: rtl/conv_pkg.sv
// Shared definitions for the row-convolution engine: output mode encodings,
// datapath width helpers and the output clamp used by the post-scale stage.
package conv_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP = 2'b00,
      MODE_SAT  = 2'b01,
      MODE_RELU = 2'b10,
      MODE_RSVD = 2'b11   // behaves as MODE_SAT
   } mode_e;

   // Width of the intermediate used by the clamp; must cover the full sum width.
   localparam int WIDE_W = 64;

   // Full-precision product width of one tap.
   function automatic int prod_w(input int data_w, input int coef_w);
      return data_w + coef_w;
   endfunction

   // Full-precision lane sum width: product plus growth for TAPS additions.
   function automatic int sum_w(input int data_w, input int coef_w, input int taps);
      return data_w + coef_w + $clog2(taps);
   endfunction

   typedef struct packed {
      logic signed [WIDE_W-1:0] val;
      logic                     clipped;
   } clamp_t;

   // Clamp v into the signed out_w range. With relu set, negatives are floored
   // to zero; that flooring is the intended function and is not a clip.
   function automatic clamp_t clamp_val(input logic signed [WIDE_W-1:0] v,
                                        input int out_w,
                                        input logic relu);
      clamp_t r;
      logic signed [WIDE_W-1:0] hi;
      logic signed [WIDE_W-1:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      r.val     = v;
      r.clipped = 1'b0;
      if (relu && (v < 64'sd0)) begin
         r.val = '0;
      end else if (v > hi) begin
         r.val     = hi;
         r.clipped = 1'b1;
      end else if (v < lo) begin
         r.val     = lo;
         r.clipped = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/conv_lane.sv
// One output lane: TAPS signed multipliers feeding the S1 product registers,
// followed by an adder and the S2 full-precision sum register.
module conv_lane
   import conv_pkg::*;
#(
   parameter  int DATA_W = 12,
   parameter  int COEF_W = 6,
   parameter  int TAPS   = 3,
   localparam int SW     = sum_w(DATA_W, COEF_W, TAPS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   adv,
   input  logic [TAPS*DATA_W-1:0] samples,
   input  logic [TAPS*COEF_W-1:0] coefs,
   output logic signed [SW-1:0]   sum
);

   localparam int PW = prod_w(DATA_W, COEF_W);

   logic signed [PW-1:0] prod [TAPS];
   logic signed [SW-1:0] acc;

   // S1: register every tap product whenever the pipeline advances.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < TAPS; k++) prod[k] <= '0;
      end else if (adv) begin
         // NOTE: state uses non-blocking assignment so every register samples pre-edge values.
         for (int k = 0; k < TAPS; k++)
            prod[k] <= PW'($signed(samples[k*DATA_W +: DATA_W])) *
                       PW'($signed(coefs[k*COEF_W +: COEF_W]));
      end
   end

   // Sign-extend each product to the sum width and add, no truncation.
   always_comb begin
      // NOTE: default assigned first so no path leaves acc unassigned (no latch).
      acc = '0;
      for (int k = 0; k < TAPS; k++) acc = acc + SW'(prod[k]);
   end

   // S2: register the lane sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   sum <= '0;
      else if (adv) sum <= acc;
   end

endmodule

// File: rtl/conv_row_engine.sv
// Row-convolution engine: LANES parallel TAPS-tap dot products over a sliding
// window, 3-stage valid/ready pipeline with global stall, post-scale shift and
// wrap/saturate/ReLU output modes, sticky saturation flag and beat counter.
module conv_row_engine
   import conv_pkg::*;
#(
   parameter  int DATA_W = 12,
   parameter  int COEF_W = 6,
   parameter  int TAPS   = 3,
   parameter  int LANES  = 10,
   parameter  int OUT_W  = 16,
   parameter  int CNT_W  = 16,
   localparam int CI_W   = (TAPS > 2) ? $clog2(TAPS) : 1,
   localparam int NS     = LANES + TAPS - 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   coef_wr_en,
   input  logic [CI_W-1:0]        coef_idx,
   input  logic [COEF_W-1:0]      coef_data,
   input  logic [1:0]             mode,
   input  logic [4:0]             shift,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NS*DATA_W-1:0]   in_data,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*OUT_W-1:0] out_data,
   output logic                   out_last,
   output logic                   sat_flag,
   input  logic                   sat_clr,
   output logic [CNT_W-1:0]       beat_cnt
);

   localparam int SW = sum_w(DATA_W, COEF_W, TAPS);

   logic                     adv;
   logic [COEF_W-1:0]        coef [TAPS];
   logic [TAPS*COEF_W-1:0]   coef_flat;
   logic signed [SW-1:0]     sums [LANES];
   logic                     v1, v2, last1, last2;
   mode_e                    mode1, mode2;
   logic [4:0]               shift1, shift2;
   logic [LANES*OUT_W-1:0]   s3_data;
   logic                     s3_clip;

   // The whole pipeline moves together; it only stops when a held output is refused.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Coefficient bank; a beat accepted on the write edge still sees the old value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the bank is small and must read as zero after reset, so it is reset like any register.
         for (int k = 0; k < TAPS; k++) coef[k] <= '0;
      end else if (coef_wr_en) begin
         for (int k = 0; k < TAPS; k++)
            if (coef_idx == CI_W'(k)) coef[k] <= coef_data;
      end
   end

   // Flatten the bank for the lanes.
   always_comb begin
      coef_flat = '0;
      for (int k = 0; k < TAPS; k++) coef_flat[k*COEF_W +: COEF_W] = coef[k];
   end

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      conv_lane #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS)) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .adv     (adv),
         .samples (in_data[j*DATA_W +: TAPS*DATA_W]),
         .coefs   (coef_flat),
         .sum     (sums[j])
      );
   end

   // S1/S2 control: valids and per-beat mode/shift/last travel with the data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1     <= 1'b0;
         v2     <= 1'b0;
         last1  <= 1'b0;
         last2  <= 1'b0;
         mode1  <= MODE_WRAP;
         mode2  <= MODE_WRAP;
         shift1 <= '0;
         shift2 <= '0;
      end else if (adv) begin
         v1     <= in_valid;
         last1  <= in_last;
         mode1  <= mode_e'(mode);
         shift1 <= shift;
         v2     <= v1;
         last2  <= last1;
         mode2  <= mode1;
         shift2 <= shift1;
      end
   end

   // S3 combinational: arithmetic shift of the full sum, then the output mode.
   always_comb begin
      logic signed [SW-1:0]     shifted;
      logic signed [WIDE_W-1:0] wide;
      clamp_t                   c;
      s3_data = '0;
      s3_clip = 1'b0;
      for (int j = 0; j < LANES; j++) begin
         shifted = sums[j] >>> shift2;
         wide    = WIDE_W'(shifted);
         c       = '0;
         case (mode2)
            MODE_WRAP: c.val = wide;
            MODE_RELU: c = clamp_val(wide, OUT_W, 1'b1);
            default:   c = clamp_val(wide, OUT_W, 1'b0);
         endcase
         s3_data[j*OUT_W +: OUT_W] = OUT_W'(c.val);
         s3_clip = s3_clip | c.clipped;
      end
   end

   // S3 output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (adv) begin
         out_valid <= v2;
         if (v2) begin
            out_data <= s3_data;
            out_last <= last2;
         end
      end
   end

   // Sticky saturation flag; a clip entering S3 beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  sat_flag <= 1'b0;
      else if (adv && v2 && s3_clip) sat_flag <= 1'b1;
      else if (sat_clr)            sat_flag <= 1'b0;
   end

   // Output handshake counter, wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      beat_cnt <= '0;
      else if (out_valid && out_ready) beat_cnt <= beat_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_conv_row_engine.sv
// Self-checking bench for conv_row_engine: directed steps plus randomized
// streams, compared against a plain-arithmetic scoreboard model.
module tb_conv_row_engine;

   localparam int DATA_W = 12;
   localparam int COEF_W = 6;
   localparam int TAPS   = 3;
   localparam int LANES  = 10;
   localparam int OUT_W  = 16;
   localparam int CNT_W  = 16;
   localparam int CI_W   = 2;
   localparam int NS     = LANES + TAPS - 1;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   coef_wr_en;
   logic [CI_W-1:0]        coef_idx;
   logic [COEF_W-1:0]      coef_data;
   logic [1:0]             mode;
   logic [4:0]             shift;
   logic                   in_valid;
   logic                   in_ready;
   logic [NS*DATA_W-1:0]   in_data;
   logic                   in_last;
   logic                   out_valid;
   logic                   out_ready;
   logic [LANES*OUT_W-1:0] out_data;
   logic                   out_last;
   logic                   sat_flag;
   logic                   sat_clr;
   logic [CNT_W-1:0]       beat_cnt;

   conv_row_engine #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS),
      .LANES(LANES), .OUT_W(OUT_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .coef_wr_en(coef_wr_en), .coef_idx(coef_idx),
      .coef_data(coef_data), .mode(mode), .shift(shift), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .sat_flag(sat_flag), .sat_clr(sat_clr),
      .beat_cnt(beat_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [LANES*OUT_W-1:0] data;
      logic                   last;
   } exp_t;

   exp_t                   sb[$];
   logic [LANES*OUT_W-1:0] pop_log[$];
   int  mcoef[TAPS];
   bit  model_sat;
   bit  ov_now;
   int  n_chk, n_pass;
   int  n_acc, n_pop, n_last;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, got, exp);
   endtask

   // Expected output of one beat, straight from the lane equation.
   function automatic exp_t model_beat(input logic [NS*DATA_W-1:0] d, input logic [1:0] m,
                                       input logic [4:0] sh, input logic lst, output bit clip);
      exp_t   e;
      longint s, v, hi, lo;
      hi   = (longint'(1) << (OUT_W - 1)) - 1;
      lo   = -(longint'(1) << (OUT_W - 1));
      clip = 0;
      e.data = '0;
      for (int j = 0; j < LANES; j++) begin
         s = 0;
         for (int k = 0; k < TAPS; k++)
            s += longint'($signed(d[(j+k)*DATA_W +: DATA_W])) * longint'(mcoef[k]);
         s = s >>> sh;
         v = s;
         if (m == 2'b10) begin
            if (s < 0) v = 0;
            else if (s > hi) begin v = hi; clip = 1; end
         end else if (m != 2'b00) begin
            if (s > hi) begin v = hi; clip = 1; end
            else if (s < lo) begin v = lo; clip = 1; end
         end
         e.data[j*OUT_W +: OUT_W] = v[OUT_W-1:0];
      end
      e.last = lst;
      return e;
   endfunction

   // One clock: observe handshakes at the falling edge, update the model, then
   // return just after the rising edge so the caller can drive new inputs.
   task automatic tick();
      bit   clip;
      exp_t e, g;
      @(negedge clk);
      ov_now = out_valid;
      if (in_valid && in_ready) begin
         e = model_beat(in_data, mode, shift, in_last, clip);
         sb.push_back(e);
         if (clip) model_sat = 1;
         n_acc++;
      end
      if (out_valid && out_ready) begin
         n_pop++;
         if (out_last) n_last++;
         check("beat_expected", (sb.size() != 0), 1);
         if (sb.size() != 0) begin
            g = sb.pop_front();
            check("out_data", out_data, g.data);
            check("out_last", out_last, g.last);
         end
         pop_log.push_back(out_data);
      end
      if (coef_wr_en && int'(coef_idx) < TAPS) mcoef[coef_idx] = int'($signed(coef_data));
      @(posedge clk);
      #1;
   endtask

   task automatic set_samples(input int kind, input int val);
      int v;
      for (int i = 0; i < NS; i++) begin
         case (kind)
            0:       v = val;
            1:       v = i;
            default: v = int'($urandom_range(0, 4095)) - 2048;
         endcase
         in_data[i*DATA_W +: DATA_W] = DATA_W'(v);
      end
   endtask

   task automatic write_coef(input int idx, input int val);
      coef_wr_en = 1;
      coef_idx   = CI_W'(idx);
      coef_data  = COEF_W'(val);
      tick();
      coef_wr_en = 0;
   endtask

   task automatic send_one();
      in_valid = 1;
      tick();
      in_valid = 0;
   endtask

   task automatic drain();
      in_valid  = 0;
      out_ready = 1;
      for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
      check("drain_empty", sb.size(), 0);
   endtask

   task automatic clear_sat();
      sat_clr = 1;
      tick();
      sat_clr   = 0;
      model_sat = 0;
   endtask

   task automatic apply_reset();
      rst_n = 0;
      in_valid = 0; in_last = 0; coef_wr_en = 0; sat_clr = 0;
      sb.delete();
      n_pop = 0; model_sat = 0;
      for (int k = 0; k < TAPS; k++) mcoef[k] = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask

   initial begin
      int lat, pop0, last0, ov_cnt;
      bit pat[4];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      n_chk = 0; n_pass = 0; n_acc = 0; n_pop = 0; n_last = 0;
      coef_idx = '0; coef_data = '0; mode = 2'b01; shift = '0;
      in_data = '0; out_ready = 0;
      apply_reset();
      rst_n = 0;
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_beat_cnt", beat_cnt, 0);
      check("rst_sat_flag", sat_flag, 0);
      check("rst_out_data", out_data, 0);
      @(posedge clk); #1 rst_n = 1;
      out_ready = 1;

      // 1: coef {1,2,3}, all ones -> 6, latency, counter
      write_coef(0, 1); write_coef(1, 2); write_coef(2, 3);
      mode = 2'b01; shift = 0; set_samples(0, 1);
      send_one();
      lat = 0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (ov_now && lat == 0) lat = i;
      end
      check("t1_latency", lat, 3);
      check("t1_lane6", pop_log[pop_log.size()-1], {LANES{16'd6}});
      check("t1_beat_cnt", beat_cnt, 1);

      // 2: coef {1,0,-1}, ramp -> -2; ReLU -> 0 without sat
      write_coef(0, 1); write_coef(1, 0); write_coef(2, -1);
      set_samples(1, 0);
      send_one(); drain();
      check("t2_sat_lane", pop_log[pop_log.size()-1], {LANES{16'hFFFE}});
      mode = 2'b10;
      send_one(); drain();
      check("t2_relu_lane", pop_log[pop_log.size()-1], {LANES{16'h0000}});
      check("t2_relu_sat_flag", sat_flag, 0);

      // 3: extreme operands, sum 196608
      for (int k = 0; k < TAPS; k++) write_coef(k, -32);
      set_samples(0, -2048);
      mode = 2'b01; shift = 0;
      send_one(); drain();
      check("t3_sat_lane", pop_log[pop_log.size()-1], {LANES{16'h7FFF}});
      check("t3_sat_flag", sat_flag, 1);
      clear_sat();
      check("t3_sat_cleared", sat_flag, 0);
      mode = 2'b00;
      send_one(); drain();
      check("t3_wrap_lane", pop_log[pop_log.size()-1], {LANES{16'h0000}});
      mode = 2'b01; shift = 4;
      send_one(); drain();
      check("t3_shift_lane", pop_log[pop_log.size()-1], {LANES{16'd12288}});
      check("t3_sat_flag_model", sat_flag, model_sat);

      // 4: 8 random beats under 1-0-0-1 backpressure
      for (int k = 0; k < TAPS; k++) write_coef(k, int'($urandom_range(0, 63)) - 32);
      pop0 = n_pop; last0 = n_last;
      begin
         int sent, acc_before;
         sent = 0;
         set_samples(2, 0); mode = 2'($urandom_range(0, 3)); shift = 5'($urandom_range(0, 7));
         in_valid = 1;
         for (int cyc = 0; cyc < 100 && sent < 8; cyc++) begin
            out_ready = pat[cyc % 4];
            in_last   = (sent == 7);
            acc_before = n_acc;
            tick();
            if (n_acc != acc_before) begin
               sent++;
               set_samples(2, 0); mode = 2'($urandom_range(0, 3)); shift = 5'($urandom_range(0, 7));
            end
         end
         check("t4_sent", sent, 8);
      end
      in_valid = 0; in_last = 0;
      drain();
      check("t4_beats_out", n_pop - pop0, 8);
      check("t4_last_count", n_last - last0, 1);
      check("t4_beat_cnt", beat_cnt, CNT_W'(n_pop));

      // 5: coefficient write racing an accept, out-of-range index
      write_coef(0, 2); write_coef(1, 0); write_coef(2, 0);
      mode = 2'b01; shift = 0; set_samples(0, 1);
      pop_log.delete();
      coef_wr_en = 1; coef_idx = 0; coef_data = COEF_W'(5); in_valid = 1;
      tick();
      coef_wr_en = 0;
      tick();
      in_valid = 0;
      drain();
      check("t5_beat_a_old", pop_log[0], {LANES{16'd2}});
      check("t5_beat_b_new", pop_log[1], {LANES{16'd5}});
      write_coef(3, 7);
      send_one(); drain();
      check("t5_idx3_ignored", pop_log[pop_log.size()-1], {LANES{16'd5}});

      // Randomized stream with random stalls, bubbles and coefficient writes
      clear_sat();
      for (int cyc = 0; cyc < 300; cyc++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 2) != 0);
         in_last    = ($urandom_range(0, 7) == 0);
         mode       = 2'($urandom_range(0, 3));
         shift      = 5'($urandom_range(0, 6));
         set_samples(2, 0);
         coef_wr_en = ($urandom_range(0, 5) == 0);
         coef_idx   = CI_W'($urandom_range(0, 3));
         coef_data  = COEF_W'($urandom_range(0, 63));
         tick();
      end
      coef_wr_en = 0; in_last = 0;
      drain();
      check("rand_sat_flag", sat_flag, model_sat);
      check("rand_beat_cnt", beat_cnt, CNT_W'(n_pop));

      // 6: reset with beats in flight, then set-wins on sat_clr
      mode = 2'b01; shift = 0; set_samples(0, 1);
      out_ready = 0; in_valid = 1;
      repeat (3) tick();
      in_valid = 0;
      check("t6_stalled_valid", out_valid, 1);
      rst_n = 0;
      #1;
      check("t6_reset_out_valid", out_valid, 0);
      check("t6_reset_beat_cnt", beat_cnt, 0);
      sb.delete(); n_pop = 0; model_sat = 0;
      for (int k = 0; k < TAPS; k++) mcoef[k] = 0;
      @(posedge clk); #1 rst_n = 1;
      out_ready = 1;
      ov_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (ov_now) ov_cnt++;
      end
      check("t6_no_output_after_reset", ov_cnt, 0);
      for (int k = 0; k < TAPS; k++) write_coef(k, -32);
      set_samples(0, -2048);
      check("t6_sat_pre", sat_flag, 0);
      send_one();
      tick();
      sat_clr = 1;
      tick();
      sat_clr = 0;
      check("t6_sat_set_wins", sat_flag, 1);
      drain();
      clear_sat();
      check("t6_sat_clr", sat_flag, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
